// File: rtl/seg_7_scan_driver_if.sv
// Bundle of the scan driver's display inputs and multiplexed segment outputs.
// master = the side that supplies digits, slave = the scan driver itself.
interface seg_7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] bin_in;
  logic [NUM_DIGITS-1:0]   dot_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   seg_select_out;
  logic [7:0]              hex_out;
  logic [2:0]              digit_idx;

  modport master (
    output enable, bin_in, dot_in, blank_in,
    input  seg_select_out, hex_out, digit_idx
  );

  modport slave (
    input  enable, bin_in, dot_in, blank_in,
    output seg_select_out, hex_out, digit_idx
  );
endinterface

// File: rtl/seg_7_scan_driver.sv
// Time-multiplexed 7-segment driver: frame-synchronous input snapshot, hex font decode,
// one registered output stage. Optional leading-zero suppression under SEG_7_LEADING_ZERO_BLANK_EN.
module seg_7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                 clk,
  input logic                 reset,
  seg_7_scan_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [2:0]              idx_p0;
  logic                    vld_p0;
  logic [4*NUM_DIGITS-1:0] bin_p0;
  logic [NUM_DIGITS-1:0]   dot_p0;
  logic [NUM_DIGITS-1:0]   blank_p0;

  // Stage p0: slot timing, digit index and frame-start snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      vld_p0   <= 1'b0;
      bin_p0   <= '0;
      dot_p0   <= '0;
      blank_p0 <= '0;
    end else begin
      vld_p0 <= 1'b1;
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? 3'd0 : idx_p0 + 3'd1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if (cnt_p0 == '0 && idx_p0 == 3'd0) begin
        bin_p0   <= bus.bin_in;
        dot_p0   <= bus.dot_in;
        blank_p0 <= bus.blank_in;
      end
    end
  end

  logic [3:0]            nib_sel;
  logic                  dot_sel;
  logic                  blank_sel;
  logic [NUM_DIGITS-1:0] anode_sel;

  always_comb begin
    nib_sel   = 4'h0;
    dot_sel   = 1'b0;
    blank_sel = 1'b0;
    anode_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_p0 == 3'(k)) begin
        nib_sel      = bin_p0[4*k +: 4];
        dot_sel      = dot_p0[k];
        blank_sel    = blank_p0[k];
        anode_sel[k] = 1'b0;
      end
    end
  end

  logic lz_blank;
`ifdef SEG_7_LEADING_ZERO_BLANK_EN
  // Digit k>0 is a leading zero when it and every higher nibble is zero and its dp is off
  always_comb begin
    lz_blank = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx_p0 == 3'(k) && (bin_p0 >> (4*k)) == '0 && !dot_p0[k])
        lz_blank = 1'b1;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  logic [NUM_DIGITS-1:0] sel_p1;
  logic [7:0]            hex_p1;
  logic [2:0]            idx_p1;

  // Stage p1: registered anode/cathode drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_p1 <= '1;
      hex_p1 <= 8'hFF;
      idx_p1 <= '0;
    end else begin
      idx_p1 <= idx_p0;
      if (!vld_p0 || !bus.enable) begin
        sel_p1 <= '1;
        hex_p1 <= 8'hFF;
      end else begin
        sel_p1 <= anode_sel;
        hex_p1 <= (blank_sel || lz_blank) ? 8'hFF : {~dot_sel, hex_font(nib_sel)};
      end
    end
  end

  assign bus.seg_select_out = sel_p1;
  assign bus.hex_out        = hex_p1;
  assign bus.digit_idx      = idx_p1;

endmodule

// File: tb/tb_seg_7_scan_driver.sv
// Self-checking bench for seg_7_scan_driver (4 digits, 4-cycle slots): directed scenarios
// followed by randomized inputs, compared against an edge-count based reference model.
module tb_seg_7_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg_7_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] font [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: e = rising edges since reset release.
  // After edge e the index register holds (e/DIV)%N; outputs show the state after edge e-1.
  int           e;
  logic [15:0]  sbin;
  logic [N-1:0] sdot;
  logic [N-1:0] sblank;
  logic [N-1:0] exp_sel;
  logic [7:0]   exp_hex;
  int           exp_idx;

  function automatic bit lz(input int d);
`ifdef SEG_7_LEADING_ZERO_BLANK_EN
    return (d > 0) && ((sbin >> (4*d)) == 16'h0) && !sdot[d];
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    int d;
    @(posedge clk);
    e++;
    d = ((e - 1) / DIV) % N;
    exp_idx = d;
    if (e < 2 || !bus.enable) begin
      exp_sel = '1;
      exp_hex = 8'hFF;
    end else begin
      exp_sel    = '1;
      exp_sel[d] = 1'b0;
      if (sblank[d] || lz(d)) exp_hex = 8'hFF;
      else begin
        exp_hex = font[sbin[4*d +: 4]];
        if (sdot[d]) exp_hex[7] = 1'b0;
      end
    end
    if ((e - 1) % (DIV * N) == 0) begin
      sbin   = bus.bin_in;
      sdot   = bus.dot_in;
      sblank = bus.blank_in;
    end
    @(negedge clk);
    check("sel", 32'(bus.seg_select_out), 32'(exp_sel));
    check("hex", 32'(bus.hex_out), 32'(exp_hex));
    check("idx", 32'(bus.digit_idx), 32'(exp_idx));
  endtask

  // Called just after a falling edge; reset rises between edges and must act at once.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_async_sel", 32'(bus.seg_select_out), 32'hF);
    check("rst_async_hex", 32'(bus.hex_out), 32'hFF);
    check("rst_async_idx", 32'(bus.digit_idx), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_sel", 32'(bus.seg_select_out), 32'hF);
    check("rst_hold_hex", 32'(bus.hex_out), 32'hFF);
    check("rst_hold_idx", 32'(bus.digit_idx), 32'h0);
    reset  = 1'b0;
    e      = 0;
    sbin   = '0;
    sdot   = '0;
    sblank = '0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.bin_in   = 16'h1234;
    bus.dot_in   = '0;
    bus.blank_in = '0;
    e = 0; sbin = '0; sdot = '0; sblank = '0;
    @(negedge clk);
    apply_reset();

    // Basic scan, then a mid-frame value change
    repeat (2 * DIV * N) tick();
    repeat (6) tick();
    bus.bin_in = 16'hABCD;
    repeat (2 * DIV * N) tick();

    // Decimal point and blanking
    bus.dot_in   = 4'b0100;
    bus.blank_in = 4'b0001;
    bus.bin_in   = 16'h1234;
    repeat (2 * DIV * N) tick();
    bus.dot_in   = '0;
    bus.blank_in = '0;

    // Display disable while scanning continues
    repeat (5) tick();
    bus.enable = 1'b0;
    repeat (6) tick();
    bus.enable = 1'b1;
    repeat (20) tick();

    // Reset while digit 2 is on the display
    for (int i = 0; i < 64 && !(e >= 2 && exp_idx == 2 && bus.enable); i++) tick();
    check("pre_rst_sel", 32'(bus.seg_select_out), 32'hB);
    apply_reset();
    tick();
    check("post_rst_edge1_sel", 32'(bus.seg_select_out), 32'hF);
    tick();
    check("post_rst_edge2_sel", 32'(bus.seg_select_out), 32'hE);
    repeat (2 * DIV * N) tick();

    // Randomized inputs
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.bin_in   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.dot_in   = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.blank_in = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.enable = ($urandom_range(0, 9) != 0);
      tick();
      if (i == 300) apply_reset();
    end
    bus.enable = 1'b1;

`ifdef SEG_7_LEADING_ZERO_BLANK_EN
    bus.dot_in   = '0;
    bus.blank_in = '0;
    bus.bin_in   = 16'h0070;
    repeat (3 * DIV * N) tick();
    bus.bin_in = 16'h0000;
    repeat (3 * DIV * N) tick();
    bus.bin_in = 16'h0500;
    bus.dot_in = 4'b0010;
    repeat (3 * DIV * N) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_7_scan_driver.md
SEG_7_SCAN_DRIVER -- requirements
Module: seg_7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, CLK cycles per digit slot; legal range 2..2^20.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ENABLE  input  1  high = display lit, low = all digits dark while scanning continues.
REQ-006 BIN_IN  input  4*NUM_DIGITS  nibble k (bits 4k+3:4k) = hex value of digit k; digit 0 is least significant.
REQ-007 DOT_IN  input  NUM_DIGITS  bit k high = decimal point of digit k lit.
REQ-008 BLANK_IN  input  NUM_DIGITS  bit k high = digit k dark.
REQ-009 SEG_SELECT_OUT  output  NUM_DIGITS  active-low one-hot anode select; bit k low = digit k driven.
REQ-010 HEX_OUT  output  8  active-low cathodes; bit0..6 = segments a..g, bit7 = dp.
REQ-011 DIGIT_IDX  output  3  index of the digit currently shown on the outputs.

Function
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; digit index SHALL advance by 1 on each wrap, from NUM_DIGITS-1 to 0.
REQ-013 With NUM_DIGITS=1, the digit index SHALL stay at 0.
REQ-014 Snapshot registers for BIN_IN, DOT_IN and BLANK_IN SHALL load only when counter=0 and index=0 (frame start), so one frame never mixes two input values.
REQ-015 Output registers SHALL update every cycle from the index and snapshot values of the previous cycle; latency is one cycle from index change to output change.
REQ-016 Decode SHALL use the standard active-low hex font: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (dp off).
REQ-017 HEX_OUT[7] SHALL be low when the snapshot dot of the shown digit is 1.
REQ-018 A blanked digit SHALL drive HEX_OUT=FF with its SEG_SELECT_OUT bit low; the slot timing is unchanged.
REQ-019 When ENABLE=0, SEG_SELECT_OUT SHALL be all ones and HEX_OUT FF from the next cycle; the counter, index and snapshot keep running.
REQ-020 DIGIT_IDX SHALL match the low bit position of SEG_SELECT_OUT, and SHALL hold the index even when ENABLE=0.
REQ-021 Exactly one SEG_SELECT_OUT bit SHALL be low at any time when ENABLE=1.

Reset
REQ-022 While RESET is high: counter=0, index=0, snapshots=0, SEG_SELECT_OUT all ones, HEX_OUT=FF, DIGIT_IDX=0.
REQ-023 Reset asserted mid-frame SHALL clear all state immediately without waiting for a clock.
REQ-024 On the first edge after release, the snapshot SHALL load (frame start); digit 0 SHALL appear on the outputs on the second edge.

Configuration
REQ-025 Macro SEG_7_LEADING_ZERO_BLANK_EN: when defined, digit k>0 SHALL be blanked when snapshot nibbles k..NUM_DIGITS-1 are all zero and dot k is 0; digit 0 is never suppressed.
REQ-026 When SEG_7_LEADING_ZERO_BLANK_EN is undefined, all digits display per REQ-016..018, and no suppression logic SHALL be synthesised.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 Reset, BIN_IN=16'h1234, ENABLE=1 -> SEG_SELECT_OUT cycles E,D,B,7, 4 clocks each; HEX_OUT cycles 99,B0,A4,F9; DIGIT_IDX 0..3.
REQ-028 Change BIN_IN to 16'hABCD mid-frame -> the current frame still shows 1234; the next frame shows A1,C6,83,88.
REQ-029 DOT_IN=4'b0100, BLANK_IN=4'b0001 -> digit 0 shows FF with anode E; digit 2 shows 24 for value 2.
REQ-030 ENABLE dropped for 6 cycles -> outputs are all ones/FF; index progression is unchanged on re-enable.
REQ-031 Assert RESET while digit 2 is shown -> outputs go to F/FF asynchronously; after release, digit 0 appears on the second edge.
REQ-032 With the macro defined, BIN_IN=16'h0070 -> digits 3 and 2 are dark, digit 1 shows F8, digit 0 shows C0; BIN_IN=0 -> only digit 0 shows C0.
